// File: rtl/mplc_data_mem_arb.sv
// Shared data-word memory: NCH core ports arbitrated round-robin onto one byte-writable
// single-port RAM, with a post-reset clear sequencer that zeroes every word.
module mplc_data_mem_arb #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int NCH   = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NCH-1:0]      REQ,
  input  logic [NCH-1:0]      WE,
  input  logic [NCH*AW-1:0]   A,
  input  logic [NCH*DW-1:0]   DI,
  input  logic [NCH*DW/8-1:0] BE,
  output logic [NCH-1:0]      GNT,
  output logic [DW-1:0]       DQ,
  output logic [NCH-1:0]      RVLD,
  output logic                ERR,
  output logic                BUSY
);

  localparam int BW = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [IW-1:0]   clr_ptr;
  logic [PW-1:0]   rr_ptr;
  logic [DW-1:0]   mem [DEPTH];

  logic            found;
  logic [PW-1:0]   win;
  logic            grant_vld;
  logic            sel_we;
  logic [AW-1:0]   sel_a;
  logic [DW-1:0]   sel_di;
  logic [BW-1:0]   sel_be;
  logic [IW-1:0]   sel_idx;
  logic            in_range;

  logic            wr_en;
  logic [IW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [BW-1:0]   wr_be;

  // Round-robin search: the port just after the last winner has top priority.
  always_comb begin
    int cand;
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (int'(rr_ptr) + k) % NCH;
      if (!found && REQ[cand]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  assign grant_vld = found && (state == RUN) && !RST;
  assign GNT       = grant_vld ? (NCH'(1) << win) : '0;
  assign BUSY      = RST || (state == CLEAR);

  assign sel_we   = WE[win];
  assign sel_a    = A[win*AW +: AW];
  assign sel_di   = DI[win*DW +: DW];
  assign sel_be   = BE[win*BW +: BW];
  assign sel_idx  = sel_a[IW-1:0];
  // Full-width compare so addresses above DEPTH never alias onto real words.
  assign in_range = (32'(sel_a) < 32'(DEPTH));

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sel_idx;
    wr_data = sel_di;
    wr_be   = sel_be;
    if (!RST && state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_ptr;
      wr_data = '0;
      wr_be   = '1;
    end else if (grant_vld && sel_we && in_range) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      rr_ptr  <= PW'(NCH - 1);
      DQ      <= '0;
      RVLD    <= '0;
      ERR     <= 1'b0;
    end else begin
      RVLD <= '0;
      ERR  <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == IW'(DEPTH - 1)) state <= RUN;
        end
        RUN: begin
          if (grant_vld) begin
            rr_ptr <= win;
            ERR    <= !in_range;
            if (!sel_we) begin
              RVLD <= GNT;
              DQ   <= in_range ? mem[sel_idx] : '0;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_mplc_data_mem_arb.sv
// Bench for mplc_data_mem_arb: directed scenarios plus random multi-port traffic,
// checked cycle by cycle against an array-based reference of the memory and arbiter.
module tb_mplc_data_mem_arb;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NCH   = 4;
  localparam int BW    = DW / 8;

  logic                CLK;
  logic                RST;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      we;
  logic [NCH*AW-1:0]   a;
  logic [NCH*DW-1:0]   di;
  logic [NCH*BW-1:0]   be;
  logic [NCH-1:0]      GNT;
  logic [DW-1:0]       DQ;
  logic [NCH-1:0]      RVLD;
  logic                ERR;
  logic                BUSY;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  mmem [DEPTH];
  int             m_rr;
  logic [DW-1:0]  m_dq;
  logic [NCH-1:0] m_rvld;
  logic           m_err;

  mplc_data_mem_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .CLK(CLK), .RST(RST), .REQ(req), .WE(we), .A(a), .DI(di), .BE(be),
    .GNT(GNT), .DQ(DQ), .RVLD(RVLD), .ERR(ERR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic w, input int addr,
                               input logic [DW-1:0] d, input logic [BW-1:0] e);
    req = '0;
    req[port] = 1'b1;
    we[port] = w;
    a[port*AW +: AW] = AW'(addr);
    di[port*DW +: DW] = d;
    be[port*BW +: BW] = e;
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    m_rr = NCH - 1;
    m_dq = '0;
    m_rvld = '0;
    m_err = 1'b0;
  endtask

  // One RUN cycle: compare outputs at the negedge, then advance the reference at the posedge.
  task automatic step(output int gw);
    int c;
    int adr;
    logic [NCH-1:0] eg;
    @(negedge CLK);
    gw = -1;
    for (int k = 1; k <= NCH; k++) begin
      c = (m_rr + k) % NCH;
      if (gw < 0 && req[c]) gw = c;
    end
    eg = '0;
    if (gw >= 0) eg[gw] = 1'b1;
    checkOutput("GNT", GNT, eg);
    checkOutput("RVLD", RVLD, m_rvld);
    checkOutput("ERR", ERR, m_err);
    checkOutput("DQ", DQ, m_dq);
    checkOutput("BUSY", BUSY, 0);
    @(posedge CLK);
    m_rvld = '0;
    m_err = 1'b0;
    if (gw >= 0) begin
      m_rr = gw;
      adr = int'(a[gw*AW +: AW]);
      m_err = (adr >= DEPTH);
      if (we[gw]) begin
        if (adr < DEPTH)
          for (int b = 0; b < BW; b++)
            if (be[gw*BW + b]) mmem[adr][b*8 +: 8] = di[gw*DW + b*8 +: 8];
      end else begin
        m_rvld = eg;
        m_dq = (adr < DEPTH) ? mmem[adr] : '0;
      end
    end
    #1;
  endtask

  task automatic idle();
    int g;
    req = '0;
    step(g);
  endtask

  // Hold RST for one edge (requests left as they are), then time the clear sequence.
  task automatic doReset();
    int n;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("RST_BUSY", BUSY, 1);
    checkOutput("RST_GNT", GNT, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    req = '1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!BUSY) break;
      n++;
      if (c == 0) begin
        checkOutput("RST_RVLD", RVLD, 0);
        checkOutput("RST_ERR", ERR, 0);
        checkOutput("RST_DQ", DQ, 0);
      end
      checkOutput("CLR_GNT", GNT, 0);
      @(posedge CLK);
      #1;
    end
    req = '0;
    checkOutput("BUSY_LEN", n, DEPTH);
    @(posedge CLK);
    #1;
    resetModel();
  endtask

  logic           pv  [NCH];
  logic           pwe [NCH];
  int             pa  [NCH];
  logic [DW-1:0]  pdi [NCH];
  logic [BW-1:0]  pbe [NCH];
  int             pw  [NCH];

  initial begin
    int g;
    RST = 1'b1;
    req = '0;
    we = '0;
    a = '0;
    di = '0;
    be = '0;
    resetModel();
    $display("[TB] start");

    doReset();

    // All four ports requesting from rr_ptr=3: grants rotate 0,1,2,3.
    req = '1;
    we = '0;
    for (int i = 0; i < NCH; i++) a[i*AW +: AW] = AW'(i);
    for (int k = 0; k < 2 * NCH; k++) begin
      step(g);
      checkOutput("RR_ORDER", g, k % NCH);
    end
    idle();

    for (int adr = 0; adr < DEPTH; adr++) begin
      applyStimulus(0, 1'b0, adr, '0, '0);
      step(g);
    end
    idle();

    applyStimulus(1, 1'b1, 5, 32'h11223344, 4'hF);
    step(g);
    applyStimulus(1, 1'b1, 5, 32'hAABBCCDD, 4'b0101);
    step(g);
    applyStimulus(1, 1'b0, 5, '0, '0);
    step(g);
    idle();
    checkOutput("BYTE_EN_DQ", DQ, 32'h11BB33DD);

    applyStimulus(2, 1'b1, 32, 32'hDEADBEEF, 4'hF);
    step(g);
    applyStimulus(2, 1'b0, 32, '0, '0);
    step(g);
    idle();
    checkOutput("OOR_DQ", DQ, 0);
    applyStimulus(0, 1'b0, 0, '0, '0);
    step(g);
    idle();
    checkOutput("OOR_MEM0", DQ, 0);

    applyStimulus(0, 1'b1, 3, 32'd500, 4'hF);
    step(g);
    applyStimulus(3, 1'b0, 3, '0, '0);
    step(g);
    idle();
    checkOutput("RAW_DQ", DQ, 32'd500);

    for (int i = 0; i < NCH; i++) begin
      pv[i] = 1'b0;
      pw[i] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i]  = 1'b1;
          pwe[i] = 1'($urandom_range(1, 0));
          pa[i]  = $urandom_range(DEPTH + 3, 0);
          pdi[i] = $urandom;
          pbe[i] = BW'($urandom_range(15, 0));
          pw[i]  = 0;
        end
        req[i] = pv[i];
        we[i] = pwe[i];
        a[i*AW +: AW] = AW'(pa[i]);
        di[i*DW +: DW] = pdi[i];
        be[i*BW +: BW] = pbe[i];
      end
      step(g);
      if (g >= 0) begin
        checkOutput("FAIR", (pw[g] < NCH), 1);
        pv[g] = 1'b0;
      end
      for (int i = 0; i < NCH; i++) if (pv[i]) pw[i]++;
    end
    idle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i % NCH, 1'b1, i, 32'hCAFE0000 + i, 4'hF);
      step(g);
    end
    applyStimulus(2, 1'b1, 7, 32'h12345678, 4'hF);
    doReset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    doReset();
    idle();
    for (int adr = 0; adr < DEPTH; adr++) begin
      applyStimulus(3, 1'b0, adr, '0, '0);
      step(g);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
